// File: rtl/bram_stream_reader_if.sv
// BRAM port bundle used between bram_mux and its masters.
// The dut modport is the master side; mem is the memory/mux side.
interface bram_intf #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 176*8
);
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] q;

    modport dut (output we, output re, output addr, output data, input q);
    modport mem (input we, input re, input addr, input data, output q);
endinterface

// File: rtl/bram_stream_reader.sv
// Burst read engine: reads len BRAM words from base_addr and streams them out over valid/ready.
// Optional macro BRAM_RD_STRIDE_EN adds a stride port (address step per read; default step is 1).
module bram_stream_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 176*8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
`ifdef BRAM_RD_STRIDE_EN
    input  logic [ADDR_W-1:0] stride,
`endif
    output logic              busy,
    output logic              done,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    bram_intf.dut             bram
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    generate
        if (RD_LAT < 1) begin : g_lat_chk
            $error("RD_LAT must be >= 1");
        end
        if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_chk
            $error("FIFO_DEPTH must be >= RD_LAT+1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                re_q, re_d;
    logic                tag_q, tag_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [RD_LAT-1:0]   vld_sr_q, vld_sr_d;
    logic [RD_LAT-1:0]   tag_sr_q, tag_sr_d;

    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic                fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic                push_s, pop_s, room_s, issue_s;
    logic [OCC_W-1:0]    occ_s;

    assign push_s  = vld_sr_q[RD_LAT-1];
    assign o_valid = (count_q != {CNT_W{1'b0}});
    assign pop_s   = o_valid & i_ready;
    assign o_data  = fifo_data_q[rd_ptr_q];
    assign o_last  = fifo_last_q[rd_ptr_q] & o_valid;
    assign busy    = busy_q;
    assign done    = done_q;

    assign bram.re   = re_q;
    assign bram.addr = addr_q;
    assign bram.we   = 1'b0;
    assign bram.data = {DATA_W{1'b0}};

    // Occupancy = FIFO words + every read still in the BRAM pipe; a new read only if a slot remains.
    always_comb begin
        occ_s = OCC_W'(count_q) + OCC_W'(re_q);
        for (int i = 0; i < RD_LAT; i++) begin
            occ_s = occ_s + OCC_W'(vld_sr_q[i]);
        end
        room_s = ((occ_s - OCC_W'(pop_s)) < OCC_W'(FIFO_DEPTH));
    end

    // Capture pipeline: valid/last tags follow each read until its q word is valid.
    always_comb begin
        vld_sr_d    = vld_sr_q;
        tag_sr_d    = tag_sr_q;
        vld_sr_d[0] = re_q;
        tag_sr_d[0] = tag_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
            tag_sr_d[i] = tag_sr_q[i-1];
        end
    end

    // Next-state, read issue and address generation.
    always_comb begin
        state_d  = state_q;
        re_d     = 1'b0;
        tag_d    = 1'b0;
        rem_d    = rem_q;
        stride_d = stride_q;
        issue_s  = 1'b0;
        if (re_q) begin
            addr_d = addr_q + stride_q;
        end else begin
            addr_d = addr_q;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
`ifdef BRAM_RD_STRIDE_EN
                    stride_d = stride;
`else
                    stride_d = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif
                    if (len == {(ADDR_W+1){1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        re_d    = 1'b1;
                        tag_d   = (len == (ADDR_W+1)'(1));
                        rem_d   = len - (ADDR_W+1)'(1);
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                issue_s = (rem_q != {(ADDR_W+1){1'b0}}) && room_s;
                if (issue_s) begin
                    re_d  = 1'b1;
                    tag_d = (rem_q == (ADDR_W+1)'(1));
                    rem_d = rem_q - (ADDR_W+1)'(1);
                end else begin
                    rem_d = rem_q;
                end
                if ((rem_q == {(ADDR_W+1){1'b0}}) || (issue_s && (rem_q == (ADDR_W+1)'(1)))) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (pop_s && fifo_last_q[rd_ptr_q]) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Control registers; reset aborts any burst and drops reads still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            re_q     <= 1'b0;
            tag_q    <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            rem_q    <= {(ADDR_W+1){1'b0}};
            stride_q <= {ADDR_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            vld_sr_q <= {RD_LAT{1'b0}};
            tag_sr_q <= {RD_LAT{1'b0}};
        end else begin
            state_q  <= state_d;
            re_q     <= re_d;
            tag_q    <= tag_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            stride_q <= stride_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            vld_sr_q <= vld_sr_d;
            tag_sr_q <= tag_sr_d;
        end
    end

    // Skid FIFO, first-word-fall-through; head is held until popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= {DATA_W{1'b0}};
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                fifo_data_q[wr_ptr_q] <= bram.q;
                fifo_last_q[wr_ptr_q] <= tag_sr_q[RD_LAT-1];
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_q <= count_q - CNT_W'(1);
            end else begin
                count_q <= count_q;
            end
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: burst table plus timing, reset and stride sequences.
module tb_bram_stream_reader;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 176*8;
    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy, done, o_valid, o_last, i_ready;
    logic [DATA_W-1:0] o_data;
    logic [ADDR_W-1:0] strd_v = 10'd1;

    bram_intf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bram ();

    bram_stream_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
`ifdef BRAM_RD_STRIDE_EN
        .stride(strd_v),
`endif
        .busy(busy), .done(done), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
        .i_ready(i_ready), .bram(bram)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        w[ADDR_W-1:0] = a;
        w[DATA_W-1 -: 16] = {6'd0, a} ^ 16'hA5A5;
        return w;
    endfunction

    // BRAM model with one cycle read latency
    always @(posedge clk) if (bram.re) bram.q <= word(bram.addr);

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = -100;
    int reads_seen = 0, beats_seen = 0, done_cnt = 0, done_cyc = 0;
    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [DATA_W:0]   exp_beat_q [$];
    int                re_cyc_q [$];
    int                beat_cyc_q [$];
    logic              hold_pending = 1'b0;
    logic [DATA_W:0]   held;

    task automatic check(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (low 64 bits) at cycle %0d", name, act[63:0], exp[63:0], cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: read addresses, beat scoreboard, stall hold, occupancy and done/busy
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if ((cyc - t0) == 1) check("busy_after_start", busy, 1);
            if (bram.re) begin
                reads_seen++;
                re_cyc_q.push_back(cyc - t0);
                if (exp_addr_q.size() == 0) check("extra_re", 1, 0);
                else check("re_addr", bram.addr, exp_addr_q.pop_front());
                check("fifo_room", (reads_seen - beats_seen) <= FIFO_DEPTH, 1);
                check("we_zero", bram.we, 0);
            end
            if (hold_pending) begin
                check("stall_valid", o_valid, 1);
                check("stall_hold", {o_last, o_data}, held);
            end
            hold_pending = o_valid && !i_ready;
            held = {o_last, o_data};
            if (o_valid && i_ready) begin
                beat_cyc_q.push_back(cyc - t0);
                if (exp_beat_q.size() == 0) check("extra_beat", 1, 0);
                else check("beat", {o_last, o_data}, exp_beat_q.pop_front());
                beats_seen++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc - t0;
                check("busy_at_done", busy, 1);
            end
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   len;
        int                mode;     // 0 ready, 1 random, 2 alternating
        int                restart;  // loop cycle of an extra start pulse, 0 = none
        int                exp_done; // expected done cycle, 0 = not checked
    } vec_t;
    vec_t vecs [9];

    task automatic push_expect(input logic [ADDR_W-1:0] base, input int n);
        logic [ADDR_W-1:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(a);
            exp_beat_q.push_back({(i == n-1), word(a)});
            a = a + strd_v;
        end
    endtask

    task automatic set_ready(input int mode);
        case (mode)
            0: i_ready = 1'b1;
            1: i_ready = 1'($urandom_range(0, 1));
            default: i_ready = (cyc % 2 == 0);
        endcase
    endtask

    task automatic run_burst(input vec_t v);
        int d0, b0, n;
        d0 = done_cnt; b0 = beats_seen; n = 0;
        push_expect(v.base, int'(v.len));
        @(posedge clk); #1;
        base_addr = v.base; len = v.len; start = 1'b1; t0 = cyc;
        set_ready(v.mode);
        while (done_cnt == d0 && n < 4000) begin
            @(posedge clk); #1;
            start = ((n + 1) == v.restart);
            if (start) begin
                base_addr = v.base ^ 10'h155;
                len = 11'd5;
            end
            set_ready(v.mode);
            n++;
        end
        start = 1'b0;
        i_ready = 1'b1;
        if (n >= 4000) check("timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("beat_count", beats_seen - b0, v.len);
        check("done_count", done_cnt - d0, 1);
        check("busy_idle", busy, 0);
        check("sb_empty", exp_beat_q.size() + exp_addr_q.size(), 0);
        if (v.exp_done != 0) check("done_cycle", done_cyc, v.exp_done);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0, n;
        vecs[0] = '{10'h010, 11'd4,    0, 0, 7};
        vecs[1] = '{10'h000, 11'd8,    1, 0, 0};
        vecs[2] = '{10'h3FE, 11'd4,    0, 0, 7};
        vecs[3] = '{10'h123, 11'd1,    0, 0, 4};
        vecs[4] = '{10'h080, 11'd8,    1, 3, 0};
        vecs[5] = '{10'h050, 11'd6,    2, 0, 0};
        vecs[6] = '{10'h3FF, 11'd3,    1, 0, 0};
        vecs[7] = '{10'h155, 11'd1024, 0, 0, 1027};
        vecs[8] = '{10'h000, 11'd0,    0, 1, 1};

        rst = 1'b1; start = 1'b0; i_ready = 1'b0; base_addr = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {busy, done, o_valid, o_last, bram.re, bram.we, bram.addr}, 0);
        rst = 1'b0;

        // Exact latency of a len=4 burst with downstream always ready
        re_cyc_q.delete();
        beat_cyc_q.delete();
        run_burst(vecs[0]);
        check("re_cycles_n", re_cyc_q.size(), 4);
        check("beat_cycles_n", beat_cyc_q.size(), 4);
        for (int i = 0; i < 4 && i < re_cyc_q.size(); i++) check("re_cycle", re_cyc_q[i], i + 1);
        for (int i = 0; i < 4 && i < beat_cyc_q.size(); i++) check("beat_cycle", beat_cyc_q[i], i + 3);

        for (int k = 0; k < 9; k++) run_burst(vecs[k]);

        // Reset after 3 of 8 beats: immediate abort, then a clean short burst
        b0 = beats_seen; n = 0;
        push_expect(10'h040, 8);
        @(posedge clk); #1;
        base_addr = 10'h040; len = 11'd8; start = 1'b1; i_ready = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (beats_seen - b0 < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("beats_before_rst", beats_seen - b0, 3);
        #1;
        rst = 1'b1;
        #1;
        check("rst_outputs", {busy, done, o_valid, o_last, bram.re, bram.addr}, 0);
        exp_addr_q.delete();
        exp_beat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reads_seen = 0; beats_seen = 0;
        check("rst_hold", {busy, done, o_valid, bram.re}, 0);
        rst = 1'b0;
        run_burst('{10'h0A0, 11'd2, 0, 0, 5});

`ifdef BRAM_RD_STRIDE_EN
        strd_v = 10'h100;
        run_burst('{10'h000, 11'd5, 0, 0, 8});
        strd_v = 10'h000;
        run_burst('{10'h2AA, 11'd3, 1, 0, 0});
        strd_v = 10'd1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
